// File: rtl/conv_pkg.sv
// Shared constants, FSM state encoding and result saturation for the
// streaming 2-D convolution engine.
package conv_pkg;

   localparam int CONV_DATA_W    = 16;
   localparam int CONV_IMG_W_MAX = 32;
   localparam int CONV_K_MAX     = 5;
   localparam int CONV_FRAC_W    = 8;

   // Full-precision products plus headroom for 25 taps.
   localparam int ACC_W = 2 * CONV_DATA_W + 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (CONV_DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

   // Takes the already-rescaled sum and clamps it into the result range.
   function automatic logic signed [CONV_DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] q);
      if (q > SAT_MAX)
         return SAT_MAX[CONV_DATA_W-1:0];
      else if (q < SAT_MIN)
         return SAT_MIN[CONV_DATA_W-1:0];
      else
         return q[CONV_DATA_W-1:0];
   endfunction

endpackage

// File: rtl/conv2d_stream_engine_if.sv
// Pixel-in / result-out valid-ready streams of the convolution engine.
interface conv2d_stream_engine_if #(
   parameter int DATA_W = 16
);
   logic                     pix_valid;
   logic                     pix_ready;
   logic signed [DATA_W-1:0] pix_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;

   modport master (
      output pix_valid, pix_data, out_ready,
      input  pix_ready, out_valid, out_data
   );

   modport slave (
      input  pix_valid, pix_data, out_ready,
      output pix_ready, out_valid, out_data
   );
endinterface

// File: rtl/conv_line_buffer.sv
// K_MAX-1 row memories addressed by column; emits one K_MAX-tall column
// (newest pixel at index 0) and shifts rows down on every write.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int DATA_W    = CONV_DATA_W,
   parameter int IMG_W_MAX = CONV_IMG_W_MAX,
   parameter int K_MAX     = CONV_K_MAX,
   parameter int ADDR_W    = $clog2(CONV_IMG_W_MAX)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [DATA_W-1:0] pix,
   output logic signed [DATA_W-1:0] col_out [K_MAX]
);

   logic signed [DATA_W-1:0] rd_q [K_MAX-1];

   assign col_out[0] = pix;

   // Reads are prefetched one pixel ahead, so rd_q already holds the column
   // for wr_addr when that pixel arrives.
   genvar gi;
   generate
      for (gi = 0; gi < K_MAX - 1; gi++) begin : g_row
         logic signed [DATA_W-1:0] mem [IMG_W_MAX];
         logic signed [DATA_W-1:0] rd_reg;
         logic signed [DATA_W-1:0] wr_val;

         if (gi == 0) begin : g_first
            assign wr_val = pix;
         end else begin : g_next
            assign wr_val = rd_q[gi-1];
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < IMG_W_MAX; i++)
                  mem[i] <= '0;
               rd_reg <= '0;
            end else begin
               if (wr_en)
                  mem[wr_addr] <= wr_val;
               if (rd_en)
                  rd_reg <= mem[rd_addr];
            end
         end

         assign rd_q[gi]      = rd_reg;
         assign col_out[gi+1] = rd_q[gi];
      end
   endgenerate

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 2-D convolution: raster pixels in, one saturated fixed-point result
// per output position out. Define CONV_RELU_EN to clamp negative results to 0.
module conv2d_stream_engine
   import conv_pkg::*;
#(
   parameter int DATA_W    = CONV_DATA_W,
   parameter int IMG_W_MAX = CONV_IMG_W_MAX,
   parameter int K_MAX     = CONV_K_MAX,
   parameter int FRAC_W    = CONV_FRAC_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [15:0]              img_w,
   input  logic [2:0]               ksize,
   input  logic [1:0]               stride,
   input  logic                     w_wr,
   input  logic [4:0]               w_addr,
   input  logic signed [DATA_W-1:0] w_data,
   conv2d_stream_engine_if.slave    s,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int AW   = $clog2(IMG_W_MAX);
   localparam int WA_W = $clog2(K_MAX * K_MAX);

   state_e                   state_reg;
   logic [15:0]              img_w_reg, row_reg, col_reg;
   logic [2:0]               ksize_reg;
   logic [1:0]               stride_reg;
   logic                     out_valid_reg, err_reg;
   logic signed [DATA_W-1:0] out_data_reg;
   logic signed [DATA_W-1:0] wbank_reg [K_MAX*K_MAX];
   logic signed [DATA_W-1:0] win_reg   [K_MAX][K_MAX];
   logic signed [DATA_W-1:0] win_next  [K_MAX][K_MAX];
   logic signed [DATA_W-1:0] col_data  [K_MAX];

   logic              cfg_ok, start_ok, accept, emit, win_hit, last_col, last_pix;
   logic [15:0]       next_col, km1, row_off, col_off;
   int                kv;
   logic signed [ACC_W-1:0]    acc;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [DATA_W-1:0]   sat_val, res_val;

   assign cfg_ok   = (ksize == 3'd1 || ksize == 3'd3 || ksize == 3'd5) &&
                     (stride == 2'd1 || stride == 2'd2) &&
                     (img_w >= {13'd0, ksize}) && (img_w <= 16'(IMG_W_MAX));
   assign start_ok = (state_reg == ST_IDLE) && start && cfg_ok;

   assign s.pix_ready = (state_reg == ST_RUN) && (!out_valid_reg || s.out_ready);
   assign s.out_valid = out_valid_reg;
   assign s.out_data  = out_data_reg;
   assign busy        = (state_reg != ST_IDLE);
   assign done        = (state_reg == ST_DONE);
   assign err         = err_reg;

   assign accept   = s.pix_valid && s.pix_ready;
   assign last_col = (col_reg == img_w_reg - 16'd1);
   assign last_pix = last_col && (row_reg == img_w_reg - 16'd1);
   assign next_col = last_col ? 16'd0 : col_reg + 16'd1;

   // Window fully inside the image and aligned to the stride grid.
   assign km1     = {13'd0, ksize_reg} - 16'd1;
   assign row_off = row_reg - km1;
   assign col_off = col_reg - km1;
   assign win_hit = (row_reg >= km1) && (col_reg >= km1) &&
                    (stride_reg == 2'd1 || (!row_off[0] && !col_off[0]));
   assign emit    = accept && win_hit;

   conv_line_buffer #(
      .DATA_W    (DATA_W),
      .IMG_W_MAX (IMG_W_MAX),
      .K_MAX     (K_MAX),
      .ADDR_W    (AW)
   ) u_line_buffer (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (start_ok || accept),
      .rd_addr (accept ? next_col[AW-1:0] : '0),
      .wr_en   (accept),
      .wr_addr (col_reg[AW-1:0]),
      .pix     (s.pix_data),
      .col_out (col_data)
   );

   always_comb begin
      for (int a = 0; a < K_MAX; a++) begin
         win_next[a][0] = col_data[a];
         for (int b = 1; b < K_MAX; b++)
            win_next[a][b] = win_reg[a][b-1];
      end
   end

   // Window index (a,b) counts rows/cols back from the newest pixel, so it
   // meets kernel tap (ksize-1-a, ksize-1-b).
   assign kv = int'(ksize_reg);

   always_comb begin
      acc  = '0;
      prod = '0;
      for (int a = 0; a < K_MAX; a++) begin
         for (int b = 0; b < K_MAX; b++) begin
            if (a < kv && b < kv) begin
               prod = win_next[a][b] * wbank_reg[WA_W'((kv - 1 - a) * K_MAX + (kv - 1 - b))];
               acc  = acc + ACC_W'(prod);
            end
         end
      end
   end

   always_comb begin
      sat_val = saturate(acc >>> FRAC_W);
`ifdef CONV_RELU_EN
      res_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
      res_val = sat_val;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         img_w_reg     <= '0;
         row_reg       <= '0;
         col_reg       <= '0;
         ksize_reg     <= '0;
         stride_reg    <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         err_reg       <= 1'b0;
         for (int i = 0; i < K_MAX * K_MAX; i++)
            wbank_reg[i] <= '0;
         for (int a = 0; a < K_MAX; a++)
            for (int b = 0; b < K_MAX; b++)
               win_reg[a][b] <= '0;
      end else begin
         err_reg <= (state_reg == ST_IDLE) && start && !cfg_ok;

         if (state_reg == ST_IDLE && w_wr && (int'(w_addr) < K_MAX * K_MAX))
            wbank_reg[WA_W'(w_addr)] <= w_data;

         if (accept)
            for (int a = 0; a < K_MAX; a++)
               for (int b = 0; b < K_MAX; b++)
                  win_reg[a][b] <= win_next[a][b];

         if (emit) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= res_val;
         end else if (s.out_ready) begin
            out_valid_reg <= 1'b0;
         end

         case (state_reg)
            ST_IDLE: begin
               if (start_ok) begin
                  img_w_reg  <= img_w;
                  ksize_reg  <= ksize;
                  stride_reg <= stride;
                  row_reg    <= '0;
                  col_reg    <= '0;
                  state_reg  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (last_pix) begin
                     state_reg <= ST_FLUSH;
                  end else begin
                     col_reg <= next_col;
                     if (last_col)
                        row_reg <= row_reg + 16'd1;
                  end
               end
            end
            ST_FLUSH: begin
               if (!out_valid_reg || s.out_ready)
                  state_reg <= ST_DONE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine: table of frames with hand-derived
// results, plus illegal-config, stall and mid-frame reset sequences.
module tb_conv2d_stream_engine;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [15:0]        img_w = '0;
   logic [2:0]         ksize = '0;
   logic [1:0]         stride = '0;
   logic               w_wr = 1'b0;
   logic [4:0]         w_addr = '0;
   logic signed [15:0] w_data = '0;
   logic               busy, done, err;

   int checks = 0;
   int errors = 0;

`ifdef CONV_RELU_EN
   localparam int NEG_SAT = 0;
`else
   localparam int NEG_SAT = -32768;
`endif

   conv2d_stream_engine_if #(.DATA_W(16)) sif ();

   conv2d_stream_engine dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .img_w  (img_w),
      .ksize  (ksize),
      .stride (stride),
      .w_wr   (w_wr),
      .w_addr (w_addr),
      .w_data (w_data),
      .s      (sif),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      int img_w;    int k;       int s;
      int pix_ramp; int pix_val;
      int w_single; int w_idx;   int w_val;
      int exp_ramp; int exp_val; int scale; int off;
      int exp_cnt;  int stall;   int wbusy;
   } vec_t;

   vec_t tv [9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int expected_at(input vec_t v, input int i);
      int n, ro, co;
      if (v.exp_ramp == 0)
         return v.exp_val;
      n  = (v.img_w - v.k) / v.s + 1;
      ro = i / n;
      co = i % n;
      return v.scale * ((ro * v.s + v.off) * v.img_w + co * v.s + v.off);
   endfunction

   function automatic bit is_hit(input vec_t v, input int p);
      int r, c;
      r = p / v.img_w;
      c = p % v.img_w;
      return (r >= v.k - 1) && (c >= v.k - 1) &&
             ((r - v.k + 1) % v.s == 0) && ((c - v.k + 1) % v.s == 0);
   endfunction

   task automatic load_weights(input vec_t v);
      for (int i = 0; i < 25; i++) begin
         w_wr   = 1'b1;
         w_addr = 5'(i);
         w_data = (v.w_single == 0 || i == v.w_idx) ? 16'(v.w_val) : 16'sd0;
         @(negedge clk);
      end
      w_wr = 1'b0;
   endtask

   task automatic run_frame(input int id, input vec_t v);
      int  pin, nout, ndone, cyc, stall_left, held, got;
      bit  stalled, lat_pend;
      pin = 0; nout = 0; ndone = 0; cyc = 0; stall_left = 0; held = 0;
      stalled = 1'b0; lat_pend = 1'b0;
      load_weights(v);
      img_w  = 16'(v.img_w);
      ksize  = 3'(v.k);
      stride = 2'(v.s);
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("f%0d_busy_after_start", id), int'(busy), 1);
      do begin
         w_wr = 1'b0;
         if (v.wbusy != 0 && cyc == 3) begin
            w_wr = 1'b1; w_addr = 5'd6; w_data = 16'sd0;
         end
         sif.pix_valid = (pin < v.img_w * v.img_w);
         sif.pix_data  = (v.pix_ramp != 0) ? 16'(pin) : 16'(v.pix_val);
         if (v.stall != 0 && !stalled && nout == 2 && sif.out_valid) begin
            stalled = 1'b1; stall_left = 10; held = int'(sif.out_data);
         end
         sif.out_ready = (stall_left == 0);
         #1;
         if (lat_pend)
            check($sformatf("f%0d_latency", id), int'(sif.out_valid), 1);
         lat_pend = 1'b0;
         if (stall_left > 0) begin
            check($sformatf("f%0d_stall_pix_ready", id), int'(sif.pix_ready), 0);
            check($sformatf("f%0d_stall_hold", id), int'(sif.out_data), held);
            stall_left--;
         end
         if (done)
            ndone++;
         if (sif.out_valid && sif.out_ready) begin
            got = int'(sif.out_data);
            $display("frame %0d result %0d data %0d", id, nout, got);
            check($sformatf("f%0d_result%0d", id, nout), got, expected_at(v, nout));
            nout++;
         end
         if (sif.pix_valid && sif.pix_ready) begin
            if (is_hit(v, pin))
               lat_pend = 1'b1;
            pin++;
         end
         @(negedge clk);
         cyc++;
      end while (ndone == 0 && cyc < 4000);
      sif.pix_valid = 1'b0;
      w_wr = 1'b0;
      check($sformatf("f%0d_result_count", id), nout, v.exp_cnt);
      check($sformatf("f%0d_done_seen", id), ndone, 1);
      check($sformatf("f%0d_idle_after_done", id), int'(busy), 0);
   endtask

   initial begin
      int bad_w [6] = '{5, 5, 33, 2, 5, 5};
      int bad_k [6] = '{4, 3, 3, 3, 0, 3};
      int bad_s [6] = '{1, 3, 1, 1, 1, 0};
      int dcount;

      tv[0] = '{5, 3, 1, 0, 1,      0, 0, 256,   0, 9,       0, 0, 9,   0, 0};
      tv[1] = '{5, 3, 2, 0, 1,      0, 0, 256,   0, 9,       0, 0, 4,   0, 0};
      tv[2] = '{7, 5, 2, 0, 1,      0, 0, 256,   0, 25,      0, 0, 4,   0, 0};
      tv[3] = '{8, 3, 1, 1, 0,      1, 6, 256,   1, 0,       1, 1, 36,  0, 0};
      tv[4] = '{6, 5, 1, 0, 32767,  0, 0, 32767, 0, 32767,   0, 0, 4,   0, 0};
      tv[5] = '{5, 5, 1, 0, -32768, 0, 0, 32767, 0, NEG_SAT, 0, 0, 1,   0, 0};
      tv[6] = '{5, 3, 1, 1, 0,      1, 6, 256,   1, 0,       1, 1, 9,   1, 1};
      tv[7] = '{3, 1, 1, 1, 0,      1, 0, 512,   1, 0,       2, 0, 9,   0, 0};
      tv[8] = '{32, 1, 2, 1, 0,     1, 0, 256,   1, 0,       1, 0, 256, 0, 0};

      sif.pix_valid = 1'b0;
      sif.pix_data  = '0;
      sif.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_pix_ready", int'(sif.pix_ready), 0);
      check("reset_out_valid", int'(sif.out_valid), 0);
      check("reset_out_data",  int'(sif.out_data), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_err",  int'(err), 0);
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         img_w  = 16'(bad_w[i]);
         ksize  = 3'(bad_k[i]);
         stride = 2'(bad_s[i]);
         start  = 1'b1;
         @(negedge clk);
         start = 1'b0;
         $display("illegal start w=%0d k=%0d s=%0d err=%0d", bad_w[i], bad_k[i], bad_s[i], err);
         check($sformatf("illegal%0d_err", i), int'(err), 1);
         check($sformatf("illegal%0d_idle", i), int'(busy), 0);
         @(negedge clk);
         check($sformatf("illegal%0d_err_pulse", i), int'(err), 0);
      end

      for (int t = 0; t < 9; t++)
         run_frame(t, tv[t]);

      // Abort a frame with an output pending, then rerun cleanly.
      load_weights(tv[0]);
      img_w = 16'd5; ksize = 3'd3; stride = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 13; i++) begin
         sif.pix_valid = 1'b1;
         sif.pix_data  = 16'sd1000;
         sif.out_ready = 1'b1;
         @(negedge clk);
      end
      sif.pix_valid = 1'b0;
      check("abort_out_valid_pending", int'(sif.out_valid), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_out_valid", int'(sif.out_valid), 0);
      check("abort_out_data", int'(sif.out_data), 0);
      check("abort_pix_ready", int'(sif.pix_ready), 0);
      dcount = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("abort_no_done", dcount, 0);
      run_frame(9, tv[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv2d_stream_engine.md
# conv2d_stream_engine

Streaming 2-D convolution engine: accepts a square image one pixel per handshake in raster order and emits one fixed-point convolution result per output position.
- Buffers K-1 image rows internally, so the image is never held as a flat array.
- Supports run-time kernel size (1/3/5) and stride (1/2).
- Generation-two successor of the CNN-layer window convolver; sits between the feature-map reader and the pooling stage.

## Interface
- DATA_W, 16, signed pixel/weight/result width
- IMG_W_MAX, 32, maximum image side; sizes line buffers
- K_MAX, 5, maximum kernel side; sizes window and weight bank
- FRAC_W, 8, fractional bits of weights; result = sum >>> FRAC_W
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches img_w/ksize/stride and begins a frame (IDLE only)
- img_w  in  16  image side in pixels
- ksize  in  3  kernel side, legal values 1, 3, 5
- stride  in  2  legal values 1, 2
- w_wr  in  1  weight write strobe (IDLE only)
- w_addr  in  5  weight index, row-major r*K_MAX+c
- w_data  in  DATA_W  signed weight
- pix_valid  in  1  input pixel valid
- pix_ready  out  1  engine accepts pixel
- pix_data  in  DATA_W  signed pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  signed saturated result
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final result handshake
- err  out  1  one-cycle pulse on rejected configuration

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - w_wr writes the weight bank.
  - start with a legal config moves to RUN.
  - start with an illegal config pulses err and stays in IDLE. Illegal means ksize∉{1,3,5}, stride∉{1,2}, img_w<ksize, or img_w>IMG_W_MAX.
- RUN:
  - Pixel accepted on pix_valid&&pix_ready.
  - Row/col counters track position; col wraps at img_w-1 and row increments.
  - Each accepted pixel shifts into the K_MAX×K_MAX window; the column is sourced from the line buffers plus the new pixel, and line buffers are updated.
- Output is generated when all of these hold:
  - row≥ksize-1 and col≥ksize-1
  - (row-ksize+1)%stride==0
  - (col-ksize+1)%stride==0
- Output count is N×N, where N=(img_w-ksize)/stride+1 (floor).
- MAC:
  - Only taps inside the ksize×ksize region aligned to the newest pixel contribute.
  - Products are full 2·DATA_W; the sum is carried in 2·DATA_W+5 bits.
  - The sum is arithmetic-shifted right by FRAC_W, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- After the last pixel (row=col=img_w-1) is accepted: state FLUSH until the last result handshake, then DONE for one cycle (done=1), then IDLE.
- The weight bank is retained across frames. Writes while busy are ignored; start while busy is ignored.

## Timing
- Reset values:
  - state IDLE; all outputs 0
  - window, line buffers and weight bank cleared to 0
- Handshake and latency:
  - pix_ready = (state==RUN) && (!out_valid || out_ready).
  - Latency is 1 cycle: out_valid rises the cycle after the window-completing pixel handshake.
  - out_data is held stable while out_valid && !out_ready.
  - Simultaneous out_ready handshake and new window-completing pixel: the new result is loaded the same edge, with no bubble.
- busy is 1 from the cycle after start until done.
- reset mid-frame: abort at the next edge, all state returns to reset values, partial frame discarded, no done.

## Configuration
- CONV_RELU_EN defined: result is clamped to ≥0 after saturation (negative results become 0).
- Undefined: signed saturated result is passed unchanged.

## Structure
- Package conv_pkg holds:
  - DATA_W/K_MAX/FRAC_W defaults
  - the state enum
  - the accumulator width constant
  - the saturate function
- One sub-module, conv_line_buffer: K_MAX-1 row FIFOs of IMG_W_MAX entries, addressed by col, emitting one K_MAX-tall column per accepted pixel.

## Test plan
- 5×5 image of all 1, ksize=3, stride=1, all weights 256 → 9 results, each 9, then done.
- Same image, stride=2 → 4 results of 9; 7×7 with ksize=5, stride=2 → 4 results.
- 8×8 ramp pix=r*8+c, ksize=3, only centre weight=256 → outputs 9,10,…,54 (interior pixels in raster order).
- All pixels and weights 32767, ksize=5 → every result 32767; pixels -32768 with weights 32767 → -32768, or 0 with CONV_RELU_EN.
- out_ready held low 10 cycles mid-frame → pix_ready low, out_data stable, no result lost or duplicated.
- ksize=4 → err pulse, remains IDLE. reset asserted mid-frame, then a fresh legal frame → correct results, with no residue from the aborted frame.
